// File: rtl/i2c_txn_sequencer_pkg.sv
// i2c_seq_pkg: shared states, error codes and MLX90640 constants for the I2C transaction sequencer
package i2c_seq_pkg;
    typedef logic [3:0] state_t;
    localparam state_t IDLE    = 4'd0;
    localparam state_t ADDR_HI = 4'd1;
    localparam state_t ADDR_LO = 4'd2;
    localparam state_t WR_HI   = 4'd3;
    localparam state_t WR_LO   = 4'd4;
    localparam state_t TURN    = 4'd5;
    localparam state_t RD_HI   = 4'd6;
    localparam state_t RD_LO   = 4'd7;
    localparam state_t FINISH  = 4'd8;
    localparam state_t ABORT   = 4'd9;
    localparam state_t DONE    = 4'd10;
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_BADCMD  = 2'd3;
    localparam logic [6:0]  MLX_DEV_ADDR   = 7'h33;
    localparam logic [15:0] MLX_ROM_BASE   = 16'h2400;
    localparam logic [15:0] MLX_STATUS_REG = 16'h8000;
    localparam logic [15:0] MLX_RAM_BASE   = 16'h0400;
    function automatic logic is_byte_state(input state_t s);
        return s inside {ADDR_HI, ADDR_LO, WR_HI, WR_LO, RD_HI, RD_LO};
    endfunction
endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// i2c_txn_sequencer_if: client command/read-stream signals plus the byte-level controller handshake
interface i2c_txn_sequencer_if #(parameter int COUNT_W = 11);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_read;
    logic [6:0]         cmd_dev_addr;
    logic [15:0]        cmd_reg_addr;
    logic [COUNT_W-1:0] cmd_word_count;
    logic [15:0]        cmd_wdata;
    logic               rd_valid;
    logic [COUNT_W-1:0] rd_index;
    logic [15:0]        rd_data;
    logic               busy;
    logic               done;
    logic               error;
    logic [1:0]         err_code;
    logic [6:0]         i2c_address;
    logic               i2c_read_write;
    logic [7:0]         i2c_transmit_data;
    logic               i2c_enable_transfer;
    logic               i2c_idle;
    logic               i2c_ack;
    logic               i2c_nack;
    logic [7:0]         i2c_received_data;
    modport master (
        output cmd_valid, cmd_read, cmd_dev_addr, cmd_reg_addr, cmd_word_count, cmd_wdata,
               i2c_idle, i2c_ack, i2c_nack, i2c_received_data,
        input  cmd_ready, rd_valid, rd_index, rd_data, busy, done, error, err_code,
               i2c_address, i2c_read_write, i2c_transmit_data, i2c_enable_transfer
    );
    modport slave (
        input  cmd_valid, cmd_read, cmd_dev_addr, cmd_reg_addr, cmd_word_count, cmd_wdata,
               i2c_idle, i2c_ack, i2c_nack, i2c_received_data,
        output cmd_ready, rd_valid, rd_index, rd_data, busy, done, error, err_code,
               i2c_address, i2c_read_write, i2c_transmit_data, i2c_enable_transfer
    );
endinterface

// File: rtl/i2c_txn_sequencer_edge_monitor.sv
// i2c_edge_monitor: two-stage history of a controller level, pulses one cycle on a 0->1 change
module i2c_edge_monitor (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_rise
);
    logic [1:0] r_hist;
    always_ff @(posedge clk) r_hist <= reset ? 2'b00 : {r_hist[0], i_level};
    assign o_rise = r_hist == 2'b01;
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: drives 16-bit-register write / burst-read transactions over the byte-level I2C controller
module i2c_txn_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int COUNT_W       = 11,
    parameter int TIMEOUT_TICKS = 24000
) (
    input logic                clk,
    input logic                reset,
    i2c_txn_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    state_t             r_state, w_next;
    logic               w_ack_rise, w_nack_rise, w_ack_ev, w_accept, w_bad, w_tmo, w_last, w_busy;
    logic [TW-1:0]      r_timer;
    logic               r_read, r_en, r_rw, r_rd_valid, r_err, r_done;
    logic [6:0]         r_addr;
    logic [7:0]         r_tx, r_hi;
    logic [15:0]        r_reg, r_wdata, r_rd_data;
    logic [COUNT_W-1:0] r_count, r_idx, r_rd_index;
    logic [1:0]         r_err_code;

    i2c_edge_monitor u_ack  (.clk(clk), .reset(reset), .i_level(bus.i2c_ack),  .o_rise(w_ack_rise));
    i2c_edge_monitor u_nack (.clk(clk), .reset(reset), .i_level(bus.i2c_nack), .o_rise(w_nack_rise));

    // a simultaneous nack suppresses the ack so the byte is never treated as accepted
    assign w_ack_ev = w_ack_rise & ~w_nack_rise;
    assign w_accept = bus.cmd_valid & bus.cmd_ready;
    assign w_bad    = bus.cmd_read && bus.cmd_word_count == '0;
    assign w_tmo    = r_timer == TW'(TIMEOUT_TICKS - 1);
    assign w_last   = r_idx == r_count - COUNT_W'(1);

    always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_bad ? DONE : ADDR_HI;
            ADDR_HI: if (w_ack_ev) w_next = ADDR_LO;
            ADDR_LO: if (w_ack_ev) w_next = r_read ? TURN : WR_HI;
            WR_HI:   if (w_ack_ev) w_next = WR_LO;
            WR_LO:   if (w_ack_ev) w_next = FINISH;
            TURN:    if (bus.i2c_idle) w_next = RD_HI;
            RD_HI:   if (w_ack_ev) w_next = RD_LO;
            RD_LO:   if (w_ack_ev) w_next = w_last ? FINISH : RD_HI;
            FINISH:  if (bus.i2c_idle) w_next = DONE;
            ABORT:   if (bus.i2c_idle || w_tmo) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (is_byte_state(r_state) && (w_nack_rise || w_tmo)) w_next = ABORT;
        if ((r_state == TURN || r_state == FINISH) && w_tmo && !bus.i2c_idle) w_next = ABORT;
    end

    always_comb begin
        w_busy                  = (r_state != IDLE) | r_done;
        bus.cmd_ready           = ~w_busy;
        bus.busy                = w_busy;
        bus.done                = r_done;
        bus.error               = r_err;
        bus.err_code            = r_err_code;
        bus.rd_valid            = r_rd_valid;
        bus.rd_index            = r_rd_index;
        bus.rd_data             = r_rd_data;
        bus.i2c_address         = r_addr;
        bus.i2c_read_write      = r_rw;
        bus.i2c_transmit_data   = r_tx;
        bus.i2c_enable_transfer = r_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0; r_read <= 1'b0; r_en <= 1'b0; r_rw <= 1'b0; r_rd_valid <= 1'b0;
            r_err <= 1'b0; r_done <= 1'b0; r_addr <= '0; r_tx <= '0; r_hi <= '0;
            r_reg <= '0; r_wdata <= '0; r_rd_data <= '0; r_count <= '0; r_idx <= '0;
            r_rd_index <= '0; r_err_code <= ERR_OK;
        end else begin
            r_done     <= r_state == DONE;
            r_rd_valid <= 1'b0;
            r_timer    <= (w_next != r_state || w_ack_rise) ? '0 : r_timer + 1'b1;
            if (w_accept) begin
                r_read     <= bus.cmd_read;
                r_reg      <= bus.cmd_reg_addr;
                r_wdata    <= bus.cmd_wdata;
                r_count    <= bus.cmd_word_count;
                r_idx      <= '0;
                r_err      <= w_bad;
                r_err_code <= w_bad ? ERR_BADCMD : ERR_OK;
                if (!w_bad) begin
                    r_addr <= bus.cmd_dev_addr;
                    r_rw   <= 1'b0;
                    r_tx   <= bus.cmd_reg_addr[15:8];
                    r_en   <= 1'b1;
                end
            end
            if (r_state == ADDR_HI && w_next == ADDR_LO) r_tx <= r_reg[7:0];
            if (r_state == ADDR_LO && w_next == WR_HI) r_tx <= r_wdata[15:8];
            if (r_state == WR_HI && w_next == WR_LO) r_tx <= r_wdata[7:0];
            if (r_state == ADDR_LO && w_next == TURN) begin
                r_en <= 1'b0;
                r_rw <= 1'b1;
            end
            if (r_state == TURN && w_next == RD_HI) r_en <= 1'b1;
            if (r_state == RD_HI && w_next == RD_LO) r_hi <= bus.i2c_received_data;
            if (r_state == RD_LO && (w_next == RD_HI || w_next == FINISH)) begin
                r_rd_data  <= {r_hi, bus.i2c_received_data};
                r_rd_valid <= 1'b1;
                r_rd_index <= r_idx;
                r_idx      <= r_idx + 1'b1;
            end
            if (w_next == FINISH || w_next == ABORT) r_en <= 1'b0;
            if (w_next == ABORT && r_state != ABORT) begin
                r_err      <= 1'b1;
                r_err_code <= (w_nack_rise && is_byte_state(r_state)) ? ERR_NACK : ERR_TIMEOUT;
            end
        end
    end
endmodule
